var_delay: RTL and testbench
============================

VAR_DELAY -- requirements
Module: var_delay

Interface
REQ-001 Parameter W, default 8, data width in bits (>=1).
REQ-002 Parameter D_MAX, default 16, maximum delay in CE-cycles (>=1); sets the number of physical stages.
REQ-003 Parameter D_INIT, default 1, delay selected after reset (0..D_MAX).
REQ-004 Localparam SW = clog2(D_MAX+1), delay-select width.
REQ-005 CLK  in  1  single clock; all state updates on its rising edge.
REQ-006 RST_N  in  1  asynchronous, active-low reset.
REQ-007 CE  in  1  clock enable; 0 = whole pipeline stalls.
REQ-008 I  in  W  input sample.
REQ-009 I_VLD  in  1  input sample valid.
REQ-010 SEL  in  SW  requested delay, in CE-cycles.
REQ-011 SEL_LD  in  1  load SEL and flush the pipeline.
REQ-012 O  out  W  delayed sample.
REQ-013 O_VLD  out  1  delayed sample valid.
REQ-014 BUSY  out  1  refill in progress after a delay change.
REQ-015 SEL_ERR  out  1  sticky flag: an out-of-range SEL was loaded.

Function
REQ-016 Pipeline shall hold D_MAX stages, each storing W data bits plus 1 valid bit.
REQ-017 CE=1: stage0 <= {I, I_VLD}, stage k <= stage k-1; CE=0: all stages, the fill counter and the FSM hold.
REQ-018 Active delay DS (register) shall select the output: DS=0 -> O=I, O_VLD=I_VLD (combinational); DS=d>0 -> O/O_VLD = stage d-1.
REQ-019 Latency shall be exactly DS CE=1 cycles; stalled cycles shall add no latency and lose no samples.
REQ-020 SEL_LD=1 at a clock edge shall act regardless of CE: DS <= min(SEL, D_MAX), all valid bits <= 0, and that cycle's input is discarded.
REQ-021 SEL > D_MAX on load shall clamp to D_MAX and set SEL_ERR, which holds until reset.
REQ-022 FSM states: RUN, FILL. SEL_LD with clamped value 0 -> RUN; with value >0 -> FILL, fill counter <= clamped value.
REQ-023 In FILL, the counter shall decrement on each CE=1 cycle; at 1->0 the FSM shall enter RUN on the same edge.
REQ-024 BUSY = 1 exactly while in FILL.
REQ-025 SEL_LD during FILL shall restart the flush and fill with the new value.
REQ-026 O_VLD shall be 0 throughout FILL by construction, since flushed valid bits propagate.
REQ-027 Data bits shall not be cleared by SEL_LD; O is don't-care whenever O_VLD=0.

Reset
REQ-028 RST_N low shall asynchronously clear all valid and data bits, set DS=D_INIT, FSM=RUN, counter=0, SEL_ERR=0.
REQ-029 Outputs during and after reset: O_VLD=0 (or I_VLD if D_INIT=0), BUSY=0, SEL_ERR=0, O=0 (or I if D_INIT=0).
REQ-030 Reset asserted mid-FILL shall abort the fill; after release the block shall run at D_INIT.

Structure
REQ-031 Shared package delay_pkg shall hold the clog2 function and the RUN/FILL state encodings.
REQ-032 One sub-module, delay_stage: a single W+1-bit register with async active-low reset and CE, instantiated D_MAX times in a generate loop.
REQ-033 Tap selection shall be a registered-select combinational mux; no other sub-modules.

Verification
REQ-034 Reset release with D_INIT=1, CE=1, I=0x01..0x05 with I_VLD=1 -> O=0x01..0x05 with O_VLD=1, each one cycle after input.
REQ-035 SEL_LD with SEL=4 while streaming -> BUSY=1 for 4 CE cycles, O_VLD=0 during FILL; the first valid output is the sample entered the cycle after the load, 4 cycles later.
REQ-036 DS=3, CE toggled 1,0,0,1,1 with I=0xA0 in the first cycle -> O=0xA0 with O_VLD=1 after the 3rd CE=1 edge, with no loss or duplicate.
REQ-037 SEL_LD SEL=31 with D_MAX=16 -> DS=16, SEL_ERR=1 and held; BUSY lasts 16 CE cycles.
REQ-038 SEL_LD SEL=0 -> BUSY stays 0 and O=I, O_VLD=I_VLD in the same cycle.
REQ-039 SEL_LD SEL=8, then SEL_LD SEL=2 at fill count 5 -> fill restarts and BUSY deasserts 2 CE cycles later; RST_N pulse mid-FILL -> BUSY=0 immediately.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared definitions for the variable-delay line: FSM encodings and a
// constant-safe ceiling log2 used to size the delay-select field.
package delay_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_FILL = 1'b1
   } state_e;

   // Returns at least 1 so a select field never collapses to zero width.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) begin
         r = r + 1;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/delay_stage.sv
// One pipeline slot of the delay line: {data, valid} with clock enable and
// a flush that clears only the valid bit.
module delay_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ce,
   input  logic         flush,
   input  logic [W:0]   d_in,
   output logic [W:0]   q_out
);

   logic [W:0] stage_d;
   logic [W:0] stage_q;

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      stage_d = stage_q;
      if (ce) begin
         stage_d = d_in;
      end
      // Bit 0 is the valid flag; data bits are left alone on a flush.
      if (flush) begin
         stage_d[0] = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q_out = stage_q;

endmodule

// File: rtl/var_delay.sv
// Variable-length delay line: D_MAX CE-gated stages, a registered tap select,
// and a RUN/FILL FSM that reports the refill window after a delay change.
module var_delay
   import delay_pkg::*;
#(
   parameter  int W      = 8,
   parameter  int D_MAX  = 16,
   parameter  int D_INIT = 1,
   localparam int SW     = clog2(D_MAX + 1)
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          CE,
   input  logic [W-1:0]  I,
   input  logic          I_VLD,
   input  logic [SW-1:0] SEL,
   input  logic          SEL_LD,
   output logic [W-1:0]  O,
   output logic          O_VLD,
   output logic          BUSY,
   output logic          SEL_ERR
);

   logic [D_MAX-1:0][W:0] tap;

   state_e        state_d, state_q;
   logic [SW-1:0] cnt_d,   cnt_q;
   logic [SW-1:0] ds_d,    ds_q;
   logic          sel_err_d, sel_err_q;

   logic          sel_over;
   logic [SW-1:0] sel_clamped;
   logic [W:0]    tap_sel;

   for (genvar k = 0; k < D_MAX; k++) begin : g_stage
      logic [W:0] stage_in;
      if (k == 0) begin : g_head
         assign stage_in = {I, I_VLD};
      end else begin : g_tail
         assign stage_in = tap[k-1];
      end

      delay_stage #(
         .W (W)
      ) u_stage (
         .clk   (CLK),
         .rst_n (RST_N),
         .ce    (CE),
         .flush (SEL_LD),
         .d_in  (stage_in),
         .q_out (tap[k])
      );
   end

   assign sel_over    = (SEL > SW'(D_MAX));
   assign sel_clamped = sel_over ? SW'(D_MAX) : SEL;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         ds_q      <= SW'(D_INIT);
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ds_q      <= ds_d;
         sel_err_q <= sel_err_d;
      end
   end

   // A load acts even while stalled; the fill count only advances on CE.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ds_d      = ds_q;
      sel_err_d = sel_err_q;
      if (SEL_LD) begin
         ds_d      = sel_clamped;
         sel_err_d = sel_err_q | sel_over;
         if (sel_clamped == '0) begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end else begin
            state_d = ST_FILL;
            cnt_d   = sel_clamped;
         end
      end else if (CE && (state_q == ST_FILL)) begin
         cnt_d = cnt_q - SW'(1);
         if (cnt_q == SW'(1)) begin
            state_d = ST_RUN;
         end
      end
   end

   always_comb begin
      tap_sel = '0;
      for (int k = 0; k < D_MAX; k++) begin
         if (ds_q == SW'(k + 1)) begin
            tap_sel = tap[k];
         end
      end

      // Zero delay bypasses the registers entirely.
      if (ds_q == '0) begin
         O     = I;
         O_VLD = I_VLD;
      end else begin
         O     = tap_sel[W:1];
         O_VLD = tap_sel[0];
      end

      BUSY    = (state_q == ST_FILL);
      SEL_ERR = sel_err_q;
   end

endmodule

// File: tb/tb_var_delay.sv
// Directed bench for var_delay (W=8, D_MAX=16, D_INIT=1): a vector table for
// streaming, load, stall and bypass behaviour, then hand-written fill sequences.
module tb_var_delay;

   localparam int W     = 8;
   localparam int D_MAX = 16;
   localparam int SW    = 5;

   typedef struct {
      logic          ce;
      logic [W-1:0]  i;
      logic          iv;
      logic [SW-1:0] sel;
      logic          ld;
      logic [W-1:0]  o;
      logic          ov;
      logic          chk_o;
      logic          busy;
      logic          err;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          ce;
   logic [W-1:0]  i_data;
   logic          i_vld;
   logic [SW-1:0] sel;
   logic          sel_ld;
   logic [W-1:0]  o_data;
   logic          o_vld;
   logic          busy;
   logic          sel_err;

   int n_tests = 0;
   int n_fail  = 0;

   vec_t vecs[$];

   var_delay #(
      .W      (W),
      .D_MAX  (D_MAX),
      .D_INIT (1)
   ) dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .CE      (ce),
      .I       (i_data),
      .I_VLD   (i_vld),
      .SEL     (sel),
      .SEL_LD  (sel_ld),
      .O       (o_data),
      .O_VLD   (o_vld),
      .BUSY    (busy),
      .SEL_ERR (sel_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic c, input logic [W-1:0] di, input logic dv,
                               input logic [SW-1:0] s, input logic l,
                               input logic [W-1:0] eo, input logic eov, input logic co,
                               input logic eb, input logic ee);
      vec_t v;
      v.ce = c;  v.i = di;  v.iv = dv;  v.sel = s;  v.ld = l;
      v.o = eo;  v.ov = eov; v.chk_o = co; v.busy = eb; v.err = ee;
      return v;
   endfunction

   task automatic drive(input logic c, input logic [W-1:0] di, input logic dv,
                        input logic [SW-1:0] s, input logic l);
      @(negedge clk);
      ce = c; i_data = di; i_vld = dv; sel = s; sel_ld = l;
      @(posedge clk);
      #1;
   endtask

   int            ce_cnt;
   logic          first_set;
   logic [W-1:0]  first_data;
   logic          vld_seen;

   initial begin
      rst_n = 1'b0; ce = 1'b0; i_data = '0; i_vld = 1'b0; sel = '0; sel_ld = 1'b0;

      // Streaming at the reset delay of 1: each sample appears one edge later.
      for (int k = 1; k <= 5; k++) begin
         vecs.push_back(mk(1, 8'(k), 1, 0, 0, 8'(k), 1, 1, 0, 0));
      end
      vecs.push_back(mk(1, 8'h06, 0, 0, 0, 8'h00, 0, 0, 0, 0));
      // Load delay 4 mid-stream: flushed, 4 busy edges, then the post-load sample.
      vecs.push_back(mk(1, 8'h10, 1, 4, 1, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(1, 8'h11, 1, 0, 0, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(1, 8'h12, 1, 0, 0, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(1, 8'h13, 1, 0, 0, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(1, 8'h14, 1, 0, 0, 8'h11, 1, 1, 0, 0));
      vecs.push_back(mk(1, 8'h15, 1, 0, 0, 8'h12, 1, 1, 0, 0));
      // Delay 3 with CE pattern 1,0,0,1,1: A0 emerges after the third enabled edge only.
      vecs.push_back(mk(1, 8'h00, 0, 3, 1, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 1, 0));
      vecs.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'hA0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'hB0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 8'hB1, 1, 0, 0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(1, 8'h00, 0, 0, 0, 8'hA0, 1, 1, 0, 0));
      vecs.push_back(mk(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
      // Zero delay: combinational bypass, no fill, even with CE low.
      vecs.push_back(mk(1, 8'h55, 1, 0, 1, 8'h55, 1, 1, 0, 0));
      vecs.push_back(mk(0, 8'h66, 1, 0, 0, 8'h66, 1, 1, 0, 0));
      vecs.push_back(mk(1, 8'h77, 0, 0, 0, 8'h00, 0, 0, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      check("rst o",     32'(o_data),  32'h0);
      check("rst o_vld", 32'(o_vld),   32'h0);
      check("rst busy",  32'(busy),    32'h0);
      check("rst err",   32'(sel_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int v = 0; v < vecs.size(); v++) begin
         drive(vecs[v].ce, vecs[v].i, vecs[v].iv, vecs[v].sel, vecs[v].ld);
         if (vecs[v].chk_o) check($sformatf("v%0d o", v), 32'(o_data), 32'(vecs[v].o));
         check($sformatf("v%0d o_vld", v), 32'(o_vld),   32'(vecs[v].ov));
         check($sformatf("v%0d busy", v),  32'(busy),    32'(vecs[v].busy));
         check($sformatf("v%0d err", v),   32'(sel_err), 32'(vecs[v].err));
      end

      // Out-of-range load clamps to D_MAX; fill length counted in enabled edges.
      drive(1, 8'h3F, 1, 5'd31, 1);
      check("clamp err",   32'(sel_err), 32'h1);
      check("clamp busy",  32'(busy),    32'h1);
      check("clamp o_vld", 32'(o_vld),   32'h0);
      ce_cnt = 0; first_set = 1'b0; first_data = '0; vld_seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         sel_ld = 1'b0; ce = (k % 3 != 2); i_data = 8'(8'h40 + k); i_vld = 1'b1;
         if (ce && !first_set) begin
            first_data = i_data;
            first_set  = 1'b1;
         end
         @(posedge clk);
         #1;
         if (ce) ce_cnt++;
         if (!busy) break;
         if (o_vld) vld_seen = 1'b1;
      end
      check("clamp fill edges", 32'(ce_cnt),  32'd16);
      check("clamp vld in fill", 32'(vld_seen), 32'h0);
      check("clamp first o",    32'(o_data),  32'h40);
      check("clamp first vld",  32'(o_vld),   32'h1);
      check("clamp err held",   32'(sel_err), 32'h1);

      // Restart a fill of 8 at count 5 with a load of 2.
      drive(1, 8'h00, 0, 5'd8, 1);
      check("ld8 busy",    32'(busy),    32'h1);
      check("ld8 err held", 32'(sel_err), 32'h1);
      for (int k = 0; k < 3; k++) begin
         drive(1, 8'h00, 0, 0, 0);
         check($sformatf("fill8 busy %0d", k), 32'(busy), 32'h1);
      end
      drive(1, 8'h20, 0, 5'd2, 1);
      check("ld2 busy",  32'(busy),  32'h1);
      check("ld2 o_vld", 32'(o_vld), 32'h0);
      drive(1, 8'h21, 1, 0, 0);
      check("fill2 busy",  32'(busy),  32'h1);
      check("fill2 o_vld", 32'(o_vld), 32'h0);
      drive(1, 8'h22, 1, 0, 0);
      check("fill2 done busy", 32'(busy),   32'h0);
      check("fill2 done o",    32'(o_data), 32'h21);
      check("fill2 done vld",  32'(o_vld),  32'h1);

      // Reset in the middle of a fill aborts it at once.
      drive(1, 8'h00, 0, 5'd8, 1);
      drive(1, 8'h00, 0, 0, 0);
      check("pre-rst busy", 32'(busy), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid-rst busy",  32'(busy),    32'h0);
      check("mid-rst o_vld", 32'(o_vld),   32'h0);
      check("mid-rst o",     32'(o_data),  32'h0);
      check("mid-rst err",   32'(sel_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 8'h77, 1, 0, 0);
      check("post-rst o",    32'(o_data), 32'h77);
      check("post-rst vld",  32'(o_vld),  32'h1);
      check("post-rst busy", 32'(busy),   32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
